// File: rtl/collision_arbiter_if.sv
// Handshake/bus bundle between the collision detectors, the arbiter and the lives counter.
interface collision_arbiter_if #(
  parameter int unsigned NUM_SOURCES = 4
) ();

  logic [NUM_SOURCES-1:0] collision;
  logic                   livesReady;
  logic                   gameOver;
  logic                   livesEnable;
  logic [2:0]             hitSource;
  logic                   invulnerable;
  logic                   halted;
  logic [7:0]             hitCount;
  logic [7:0]             dropCount;

  modport master (
    input  collision,
    input  livesReady,
    input  gameOver,
    output livesEnable,
    output hitSource,
    output invulnerable,
    output halted,
    output hitCount,
    output dropCount
  );

  modport slave (
    output collision,
    output livesReady,
    output gameOver,
    input  livesEnable,
    input  hitSource,
    input  invulnerable,
    input  halted,
    input  hitCount,
    input  dropCount
  );

endinterface

// File: rtl/collision_arbiter.sv
// Round-robin collision arbiter driving the lives-counter handshake, with an invulnerability window.
// Define COLLISION_ARBITER_STATS_EN to build the saturating hitCount/dropCount counters.
module collision_arbiter #(
  parameter int unsigned NUM_SOURCES   = 4,
  parameter int unsigned INVULN_CYCLES = 50_000_000
) (
  input logic                 clock,
  input logic                 reset,
  collision_arbiter_if.master bus
);

  localparam int          Ns         = int'(NUM_SOURCES);
  localparam logic [31:0] InvulnLoad = 32'(INVULN_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StRelease, StInvuln, StHalt} state_e;

  state_e                 state_q;
  logic [NUM_SOURCES-1:0] prev_q;
  logic [NUM_SOURCES-1:0] pending_q;
  logic [NUM_SOURCES-1:0] edges;
  logic [NUM_SOURCES-1:0] winner_oh;
  logic [2:0]             rr_ptr_q;
  logic [2:0]             winner;
  logic [2:0]             winner_next;
  logic                   found;
  logic [31:0]            count_q;
  logic                   lives_enable_q;
  logic                   invulnerable_q;
  logic                   halted_q;
  logic [2:0]             hit_source_q;
  logic                   grant;
  logic                   release_done;

  assign edges = bus.collision & ~prev_q;

  // First pending source at or above rr_ptr_q, wrapping past the top.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < Ns; i++) begin
      for (int j = 0; j < Ns; j++) begin
        if (!found && pending_q[j] &&
            ((int'(rr_ptr_q) + i == j) || (int'(rr_ptr_q) + i - Ns == j))) begin
          found  = 1'b1;
          winner = 3'(j);
        end
      end
    end
  end

  always_comb begin
    winner_oh = '0;
    for (int j = 0; j < Ns; j++) begin
      winner_oh[j] = (winner == 3'(j));
    end
  end

  assign winner_next  = (winner == 3'(Ns - 1)) ? 3'd0 : winner + 3'd1;
  assign grant        = (state_q == StIdle) && !bus.gameOver && found && bus.livesReady;
  assign release_done = (state_q == StRelease) && !bus.gameOver && bus.livesReady;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      prev_q         <= '0;
      pending_q      <= '0;
      rr_ptr_q       <= '0;
      count_q        <= '0;
      lives_enable_q <= 1'b0;
      hit_source_q   <= '0;
      invulnerable_q <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      prev_q <= bus.collision;
      if (bus.gameOver) begin
        state_q        <= StHalt;
        lives_enable_q <= 1'b0;
        halted_q       <= 1'b1;
        invulnerable_q <= 1'b0;
        pending_q      <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (grant) begin
              // A fresh edge on the winner re-arms its bit: set beats clear.
              pending_q      <= (pending_q & ~winner_oh) | edges;
              hit_source_q   <= winner;
              rr_ptr_q       <= winner_next;
              lives_enable_q <= 1'b1;
              state_q        <= StIssue;
            end else begin
              pending_q <= pending_q | edges;
            end
          end
          StIssue: begin
            pending_q <= pending_q | edges;
            if (!bus.livesReady) begin
              lives_enable_q <= 1'b0;
              state_q        <= StRelease;
            end
          end
          StRelease: begin
            if (release_done) begin
              pending_q      <= '0;
              count_q        <= InvulnLoad;
              invulnerable_q <= 1'b1;
              state_q        <= StInvuln;
            end else begin
              pending_q <= pending_q | edges;
            end
          end
          StInvuln: begin
            if (count_q == '0) begin
              invulnerable_q <= 1'b0;
              state_q        <= StIdle;
            end else begin
              count_q <= count_q - 32'd1;
            end
          end
          StHalt: begin
            halted_q <= 1'b1;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign bus.livesEnable  = lives_enable_q;
  assign bus.hitSource    = hit_source_q;
  assign bus.invulnerable = invulnerable_q;
  assign bus.halted       = halted_q;

`ifdef COLLISION_ARBITER_STATS_EN
  logic [7:0] hit_count_q;
  logic [7:0] drop_count_q;
  logic [3:0] drop_amt;
  logic [8:0] drop_sum;
  logic       invuln_live;

  function automatic logic [3:0] popcount(input logic [NUM_SOURCES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < Ns; i++) begin
      n = n + 4'(v[i]);
    end
    return n;
  endfunction

  assign invuln_live = (state_q == StInvuln) && !bus.gameOver;

  // Edges landing on the release cycle are discarded together with the pending set.
  always_comb begin
    drop_amt = '0;
    if (release_done) begin
      drop_amt = popcount(pending_q | edges);
    end else if (invuln_live) begin
      drop_amt = popcount(edges);
    end
    drop_sum = {1'b0, drop_count_q} + 9'(drop_amt);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      if (grant && (hit_count_q != 8'hff)) begin
        hit_count_q <= hit_count_q + 8'd1;
      end
      drop_count_q <= drop_sum[8] ? 8'hff : drop_sum[7:0];
    end
  end

  assign bus.hitCount  = hit_count_q;
  assign bus.dropCount = drop_count_q;
`else
  assign bus.hitCount  = 8'd0;
  assign bus.dropCount = 8'd0;
`endif

endmodule

// File: tb/tb_collision_arbiter.sv
// Bench for collision_arbiter: directed table, corner sequences and random traffic vs a reference model.
module tb_collision_arbiter;

  localparam int unsigned NS  = 4;
  localparam int unsigned INV = 16;
`ifdef COLLISION_ARBITER_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;

  collision_arbiter_if #(.NUM_SOURCES(NS)) bus ();

  collision_arbiter #(
    .NUM_SOURCES  (NS),
    .INVULN_CYCLES(INV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Lives-counter responder.
  int lives;
  int low_left;
  bit go_en;
  bit auto_ready;
  bit rand_ack;

  // Reference model: pending set, outstanding request, wait for ready, window length left.
  bit [NS-1:0] m_prev;
  bit [NS-1:0] m_wait;
  int          m_rr, m_src, m_window, m_hits, m_drops;
  bit          m_en, m_wait_ready, m_halted;

  typedef struct {
    logic [NS-1:0] col;
    logic          rdy;
    int            cycles;
    logic          en;
    logic [2:0]    src;
    logic          inv;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int popc(input bit [NS-1:0] v);
    int n = 0;
    for (int i = 0; i < NS; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_wait = '0; m_rr = 0; m_src = 0; m_window = 0;
    m_hits = 0; m_drops = 0; m_en = 0; m_wait_ready = 0; m_halted = 0;
  endtask

  task automatic model_step(input bit [NS-1:0] c, input bit rdy, input bit go);
    bit [NS-1:0] e;
    int w;
    e = c & ~m_prev;
    m_prev = c;
    if (m_halted) return;
    if (go) begin
      m_halted = 1; m_en = 0; m_wait_ready = 0; m_window = 0; m_wait = '0;
      return;
    end
    if (m_window > 0) begin
      m_drops = sat(m_drops + popc(e));
      m_window--;
    end else if (m_en) begin
      m_wait |= e;
      if (!rdy) begin m_en = 0; m_wait_ready = 1; end
    end else if (m_wait_ready) begin
      if (rdy) begin
        m_drops = sat(m_drops + popc(m_wait | e));
        m_wait = '0; m_wait_ready = 0; m_window = INV;
      end else begin
        m_wait |= e;
      end
    end else begin
      w = -1;
      for (int k = 0; k < NS; k++) begin
        int s = (m_rr + k) % NS;
        if (w < 0 && m_wait[s]) w = s;
      end
      if (w >= 0 && rdy) begin
        m_wait[w] = 0;
        m_wait |= e;
        m_src = w;
        m_rr = (w + 1) % NS;
        m_en = 1;
        m_hits = sat(m_hits + 1);
      end else begin
        m_wait |= e;
      end
    end
  endtask

  function automatic logic [21:0] exp_vec();
    return {m_en, 3'(m_src), (m_window > 0), m_halted,
            StatsOn ? 8'(m_hits) : 8'd0, StatsOn ? 8'(m_drops) : 8'd0};
  endfunction

  function automatic logic [21:0] act_vec();
    return {bus.livesEnable, bus.hitSource, bus.invulnerable, bus.halted,
            bus.hitCount, bus.dropCount};
  endfunction

  task automatic lives_step();
    if (!bus.livesReady) begin
      if (low_left == 0) bus.livesReady = 1'b1;
      else low_left--;
    end else if (bus.livesEnable && lives > 0) begin
      lives--;
      bus.livesReady = 1'b0;
      low_left = rand_ack ? int'($urandom_range(0, 3)) : 1;
    end
    bus.gameOver = go_en && (lives == 0);
  endtask

  // One clock: inputs already driven are sampled at the rising edge, outputs checked at the falling one.
  task automatic tick();
    bit [NS-1:0] c;
    bit r, g;
    c = bus.collision; r = bus.livesReady; g = bus.gameOver;
    @(negedge clock);
    model_step(c, r, g);
    check("model", 32'(act_vec()), 32'(exp_vec()));
    if (auto_ready) lives_step();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.collision = '0; bus.livesReady = 1'b1; bus.gameOver = 1'b0;
    low_left = 0; go_en = 0; rand_ack = 0;
    repeat (2) @(negedge clock);
    model_reset();
    check("reset_state", 32'(act_vec()), 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises, inv_n;
    bit seen, pe;
    logic [7:0] d0, h0;
    logic [31:0] r;

    tbl.push_back('{4'b0000, 1'b1, 2,  1'b0, 3'd0, 1'b0});
    tbl.push_back('{4'b0100, 1'b1, 1,  1'b0, 3'd0, 1'b0});
    tbl.push_back('{4'b0000, 1'b1, 1,  1'b1, 3'd2, 1'b0});
    tbl.push_back('{4'b0000, 1'b1, 2,  1'b1, 3'd2, 1'b0});
    tbl.push_back('{4'b0000, 1'b0, 1,  1'b0, 3'd2, 1'b0});
    tbl.push_back('{4'b0000, 1'b0, 2,  1'b0, 3'd2, 1'b0});
    tbl.push_back('{4'b0000, 1'b1, 16, 1'b0, 3'd2, 1'b1});
    tbl.push_back('{4'b0000, 1'b1, 1,  1'b0, 3'd2, 1'b0});
    tbl.push_back('{4'b1001, 1'b1, 1,  1'b0, 3'd2, 1'b0});
    tbl.push_back('{4'b0000, 1'b1, 1,  1'b1, 3'd3, 1'b0});
    tbl.push_back('{4'b0000, 1'b0, 1,  1'b0, 3'd3, 1'b0});
    tbl.push_back('{4'b0000, 1'b1, 16, 1'b0, 3'd3, 1'b1});
    tbl.push_back('{4'b0000, 1'b1, 1,  1'b0, 3'd3, 1'b0});
    tbl.push_back('{4'b1001, 1'b1, 1,  1'b0, 3'd3, 1'b0});
    tbl.push_back('{4'b0000, 1'b1, 1,  1'b1, 3'd0, 1'b0});
    tbl.push_back('{4'b0000, 1'b0, 1,  1'b0, 3'd0, 1'b0});
    tbl.push_back('{4'b0000, 1'b1, 16, 1'b0, 3'd0, 1'b1});
    tbl.push_back('{4'b0000, 1'b1, 2,  1'b0, 3'd0, 1'b0});

    // Directed table with the bench driving livesReady itself.
    auto_ready = 0;
    do_reset();
    foreach (tbl[i]) begin
      for (int n = 0; n < tbl[i].cycles; n++) begin
        bus.collision  = tbl[i].col;
        bus.livesReady = tbl[i].rdy;
        tick();
        check("table", 32'({bus.livesEnable, bus.hitSource, bus.invulnerable}),
              32'({tbl[i].en, tbl[i].src, tbl[i].inv}));
      end
    end
    check("table_drops", 32'(bus.dropCount), StatsOn ? 32'd2 : 32'd0);

    // Single hit with a three-life counter, then five edges inside the window.
    do_reset();
    auto_ready = 1; lives = 3; go_en = 1;
    bus.collision = 4'b0100; tick();
    bus.collision = '0; tick();
    check("single_grant", 32'({bus.livesEnable, bus.hitSource}), 32'({1'b1, 3'd2}));
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      seen = bus.invulnerable;
    end
    check("window_start", 32'(seen), 32'd1);
    check("lives_after_hit", 32'(lives), 32'd2);
    inv_n = 1; rises = 0; d0 = bus.dropCount;
    for (int k = 0; k < 10; k++) begin
      bus.collision = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      pe = bus.livesEnable;
      tick();
      if (bus.livesEnable && !pe) rises++;
      if (bus.invulnerable) inv_n++;
    end
    bus.collision = '0;
    for (int k = 0; k < 30 && bus.invulnerable; k++) begin
      pe = bus.livesEnable;
      tick();
      if (bus.livesEnable && !pe) rises++;
      if (bus.invulnerable) inv_n++;
    end
    check("window_len", 32'(inv_n), 32'(INV));
    check("no_grant_in_window", 32'(rises), 32'd0);
    check("drops_in_window", 32'(bus.dropCount) - 32'(d0), StatsOn ? 32'd5 : 32'd0);
    check("lives_unchanged", 32'(lives), 32'd2);

    // Two more spaced hits exhaust the lives; the arbiter must halt.
    for (int h = 0; h < 2; h++) begin
      bus.collision = '0;
      bus.collision[h] = 1'b1;
      tick();
      bus.collision = '0;
      repeat (30) tick();
    end
    check("lives_zero", 32'(lives), 32'd0);
    check("halted_after_gameover", 32'(bus.halted), 32'd1);
    check("hits_at_gameover", 32'(bus.hitCount), StatsOn ? 32'd3 : 32'd0);
    h0 = bus.hitCount;
    bus.collision = 4'b0001; tick();
    bus.collision = '0; rises = 0;
    repeat (10) begin
      pe = bus.livesEnable;
      tick();
      if (bus.livesEnable && !pe) rises++;
    end
    check("no_grant_after_halt", 32'(rises), 32'd0);
    check("hits_frozen", 32'(bus.hitCount), 32'(h0));
    check("still_halted", 32'(bus.halted), 32'd1);

    // Reset pulled low while the request is outstanding.
    do_reset();
    auto_ready = 0; bus.livesReady = 1'b1;
    bus.collision = 4'b0001; tick();
    bus.collision = '0; tick();
    check("issue_before_reset", 32'(bus.livesEnable), 32'd1);
    #2 reset = 1'b0;
    #1 check("async_reset_outputs", 32'(act_vec()), 32'd0);
    @(negedge clock);
    model_reset();
    bus.collision = '0;
    reset = 1'b1;
    bus.collision = 4'b1000; tick();
    bus.collision = '0; tick();
    check("grant_after_reset", 32'({bus.livesEnable, bus.hitSource}), 32'({1'b1, 3'd3}));

    // A level held high is a single edge.
    do_reset();
    auto_ready = 1; lives = 1000; go_en = 0;
    bus.collision = 4'b0100; rises = 0;
    repeat (60) begin
      pe = bus.livesEnable;
      tick();
      if (bus.livesEnable && !pe) rises++;
    end
    check("held_single_edge", 32'(rises), 32'd1);
    bus.collision = '0;
    repeat (5) tick();

    // Random traffic with random acknowledge lengths.
    do_reset();
    auto_ready = 1; lives = 100000; go_en = 0; rand_ack = 1;
    for (int n = 0; n < 2500; n++) begin
      r = $urandom & $urandom & $urandom;
      bus.collision = bus.collision ^ r[NS-1:0];
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/collision_arbiter.md
# collision_arbiter

Collects collision pulses from several obstacle/hazard sources, selects one at a time with round-robin fairness, and drives the enable/ready handshake of the lives counter block. After each accepted hit it imposes an invulnerability window during which further collisions are discarded. On game over it stops issuing hits. It sits between the collision detectors and the lives/LED counter in the game top level.

## Interface
- `NUM_SOURCES`, default 4: number of collision inputs, range 2..8.
- `INVULN_CYCLES`, default 50_000_000: invulnerability length in clock cycles (1 s at 50 MHz), range 1..2^32-1.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `collision`  in  NUM_SOURCES  level collision flags, one per source, already synchronous to `clock`.
- `livesReady`  in  1  ready from the lives counter.
- `gameOver`  in  1  game-over flag from the lives counter.
- `livesEnable`  out  1  decrement request to the lives counter.
- `hitSource`  out  3  index of the most recently granted source.
- `invulnerable`  out  1  high while the invulnerability window runs.
- `halted`  out  1  high once game over has been seen.
- `hitCount`  out  8  accepted hits, saturating at 255 (stats build only).
- `dropCount`  out  8  discarded collision edges, saturating at 255 (stats build only).

## Operation
- **Edge detect.** `collision` is registered into `prev`. A rising edge is `collision & ~prev`, and each edge sets its bit in the `pending[NUM_SOURCES-1:0]` register.
- **States.** IDLE, ISSUE, RELEASE, INVULN, HALT.
- **IDLE.** If `pending != 0`, pick the winner: the first set bit searching upward from `rrPtr` with wrap-around.
  - Clear that pending bit, load `hitSource` with the winner, and set `rrPtr = (winner+1) mod NUM_SOURCES`.
  - Set `livesEnable = 1` and go to ISSUE.
- **ISSUE.** Hold `livesEnable = 1` until `livesReady == 0`, which means the counter has accepted the request. Then set `livesEnable = 0` and go to RELEASE.
- **RELEASE.** Wait for `livesReady == 1`. Then load the counter with `INVULN_CYCLES-1`, clear all pending bits, and go to INVULN.
  - Every pending bit cleared at this point adds 1 to `dropCount`.
- **INVULN.** The counter decrements once per cycle. New edges are counted in `dropCount` and never set pending. When the counter reaches 0, go to IDLE.
- **HALT.** Sampled in any state, `gameOver == 1` forces HALT on the next edge, sets `livesEnable = 0` and `halted = 1`, and clears pending. HALT exits only on reset.
- **Simultaneous set and clear.** If a pending bit is cleared by a grant in the same cycle a new edge arrives on that source, the set wins.
- **Multiple edges.** Several edges in one cycle all become pending. They are served one per hit, each followed by its own invulnerability window, unless they are dropped at RELEASE.
- **Counters.** `hitCount` increments by 1 on each IDLE→ISSUE transition. Both counters saturate at 255 and never wrap.
- `invulnerable` is 1 exactly while in INVULN. `rrPtr` resets to 0.

## Timing
- **Reset values:** `livesEnable` 0, `hitSource` 0, `invulnerable` 0, `halted` 0, `hitCount` 0, `dropCount` 0, `pending` 0, `prev` 0, state IDLE.
- Reset asserted mid-handshake drops `livesEnable` asynchronously. The lives block is reset by the same signal.
- **Latency:** a rising edge sampled at edge k sets pending at k. The grant is made at k+1, with `livesEnable` high after k+1.
- **Handshake ordering:** `livesEnable` never rises while `livesReady == 0`. It remains high for at least 1 cycle and at most until the counter acknowledges.
- INVULN lasts exactly `INVULN_CYCLES` cycles. The first IDLE cycle after it may grant immediately.
- A collision held high continuously produces only one edge.

## Configuration
- `COLLISION_ARBITER_STATS_EN`: when defined, the `hitCount` and `dropCount` registers and their saturation logic are compiled in.
- When undefined, both ports are tied to 8'd0 and no counter flops exist. Arbitration and timing are unchanged.

## Test plan
- **Single hit.** Pulse `collision[2]` for 1 cycle with a lives model (`MAX_LIVES` 3) → `livesEnable` high 2 cycles later, `hitSource` = 2, lives go to 2, then `invulnerable` high for exactly `INVULN_CYCLES` (use 16 in the bench).
- **Round-robin.** Raise `collision[0]` and `collision[3]` together in IDLE with `rrPtr` = 0 → source 0 is granted. The source-3 pending bit is dropped at RELEASE, giving `dropCount` = 1. The next simultaneous 0+3 is granted to 3.
- **Invulnerability drop.** 5 edges on `collision[1]` during INVULN → no `livesEnable`, `dropCount` += 5, lives unchanged.
- **Game over.** 3 spaced hits → after the third, `gameOver` = 1 gives `halted` = 1. A further edge yields no `livesEnable` and leaves `hitCount` = 3.
- **Reset mid-handshake.** Assert `reset` low while in ISSUE → `livesEnable` = 0 immediately, all outputs at reset values. Release reset and apply a hit → normal grant.
- **Stats build off.** Compile without the macro and rerun the single-hit scenario → `hitCount` = `dropCount` = 0 throughout, with identical grant timing.
